clark_multi: RTL and testbench

Parametrised Clarke transform for the FOC current path: converts sampled phase currents into stationary-frame Ialpha/Ibeta ahead of the Park stage. It supports run-time selection between two-shunt mode (Iu, Iv; Iw implied) and three-shunt mode (Iu, Iv, Iw measured). It captures its inputs on the start edge, runs a fixed 3-stage pipeline and saturates both results to the output width. Busy and done strobes are provided for the controller FSM.

---
 rtl/clark_multi_if.sv | 35 +++
 rtl/clark_multi.sv | 188 ++++++++++++++++++
 tb/tb_clark_multi.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clark_multi_if.sv
// clark_multi_if: start/mode/phase-current inputs and result/status outputs
// of the Clarke transform, bundled for the controller (master) and the
// transform block (slave).
//   iC_en            start request, rising edge starts a conversion
//   iMode            0 = two-shunt, 1 = three-shunt
//   iIu, iIv, iIw    signed phase currents (DATA_W)
//   oIalpha, oIbeta  signed stationary-frame results (DATA_W)
//   oSat             either result clipped in the last conversion
//   oBusy            conversion in progress
//   oC_done          one-cycle results-valid pulse
// DATA_W must match the DATA_W of the clark_multi instance it connects to.
interface clark_multi_if #(
  parameter int DATA_W = 12
);
  logic                     iC_en;
  logic                     iMode;
  logic signed [DATA_W-1:0] iIu;
  logic signed [DATA_W-1:0] iIv;
  logic signed [DATA_W-1:0] iIw;
  logic signed [DATA_W-1:0] oIalpha;
  logic signed [DATA_W-1:0] oIbeta;
  logic                     oSat;
  logic                     oBusy;
  logic                     oC_done;

  modport master (
    output iC_en, iMode, iIu, iIv, iIw,
    input  oIalpha, oIbeta, oSat, oBusy, oC_done
  );

  modport slave (
    input  iC_en, iMode, iIu, iIv, iIw,
    output oIalpha, oIbeta, oSat, oBusy, oC_done
  );
endinterface

// File: rtl/clark_multi.sv
// clark_multi: Clarke transform for the FOC current path. Phase currents are
// captured on a rising edge of iC_en, run through a 3-stage pipeline
// (pre-sum, multiply, saturate) and presented as Ialpha/Ibeta with a done
// pulse. Two-shunt mode derives Iw implicitly; three-shunt uses all three.
// Ports:
//   iClk   clock
//   iRst   synchronous active-high reset
//   bus    clark_multi_if slave modport (start, mode, currents, results,
//          oSat / oBusy / oC_done status)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a rising edge of iC_en; inputs latched on start
// CAP   | pre-sums formed from the latched currents
// MUL   | coefficient products formed, scaled back by COEF_W
// OUT   | results saturated and registered, done pulse, back to IDLE
module clark_multi #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 10
) (
  input  logic         iClk,
  input  logic         iRst,
  clark_multi_if.slave bus
);

  // round(N/sqrt(3)) with N = 2^cw-1, found as the largest k satisfying
  // 3*(2k-1)^2 <= 4*N^2 (i.e. k - 0.5 <= N/sqrt(3)); the test is monotonic
  // in k so a bitwise search from the MSB suffices.
  function automatic int calc_k_s3(input int cw);
    longint n;
    longint lim;
    longint k;
    longint t;
    n   = (longint'(1) << cw) - 1;
    lim = 4 * n * n;
    k   = 0;
    for (int b = cw; b >= 0; b--) begin
      t = k | (longint'(1) << b);
      if (3 * (2 * t - 1) * (2 * t - 1) <= lim) k = t;
    end
    return int'(k);
  endfunction

  localparam int K_S3 = calc_k_s3(COEF_W);
  // round(N/3) = floor((2N+3)/6)
  localparam int K_3  = ((2 ** COEF_W - 1) * 2 + 3) / 6;

  localparam int SW = DATA_W + 2;
  localparam int PW = DATA_W + COEF_W + 3;

  localparam logic signed [PW-1:0] K_S3_P = PW'(K_S3);
  localparam logic signed [PW-1:0] K_3_P  = PW'(K_3);
  localparam logic signed [PW-1:0] MAX_P  = PW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW-1:0] MIN_P  = PW'(-(2 ** (DATA_W - 1)));

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAP  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]               state;
  logic                     en_d;
  logic                     mode_q;
  logic signed [DATA_W-1:0] iu_q, iv_q, iw_q;
  logic signed [SW-1:0]     a_q, b1_q, b2_q;
  logic signed [PW-1:0]     alpha_f, beta_f;

  logic signed [SW-1:0]     iu_x, iv_x, iw_x;
  logic signed [SW-1:0]     a_n, b1_n, b2_n;
  logic signed [PW-1:0]     a_x, b1_x, b2_x;
  logic signed [PW-1:0]     prod_a, prod_b1, prod_b2;
  logic signed [PW-1:0]     alpha_n, beta_n;
  logic                     alpha_hi, alpha_lo, beta_hi, beta_lo;
  logic                     start;

  assign start = bus.iC_en & ~en_d;

  assign iu_x = {{(SW-DATA_W){iu_q[DATA_W-1]}}, iu_q};
  assign iv_x = {{(SW-DATA_W){iv_q[DATA_W-1]}}, iv_q};
  assign iw_x = {{(SW-DATA_W){iw_q[DATA_W-1]}}, iw_q};

  // Mode 0 keeps Iu and Iv apart for beta so each gets its own shift
  // (Iu/sqrt3 + 2*Iv/sqrt3); mode 1 reuses b1 as the single beta pre-sum.
  always_comb begin
    a_n  = '0;
    b1_n = '0;
    b2_n = '0;
    if (mode_q) begin
      a_n  = iu_x + iu_x - iv_x - iw_x;
      b1_n = iv_x - iw_x;
    end else begin
      a_n  = iu_x;
      b1_n = iu_x;
      b2_n = iv_x;
    end
  end

  assign a_x  = {{(PW-SW){a_q[SW-1]}},  a_q};
  assign b1_x = {{(PW-SW){b1_q[SW-1]}}, b1_q};
  assign b2_x = {{(PW-SW){b2_q[SW-1]}}, b2_q};

  assign prod_a  = a_x  * K_3_P;
  assign prod_b1 = b1_x * K_S3_P;
  assign prod_b2 = b2_x * K_S3_P;

  always_comb begin
    alpha_n = '0;
    beta_n  = '0;
    if (mode_q) begin
      alpha_n = prod_a >>> COEF_W;
      beta_n  = prod_b1 >>> COEF_W;
    end else begin
      alpha_n = a_x;
      beta_n  = (prod_b1 >>> COEF_W) + (prod_b2 >>> (COEF_W - 1));
    end
  end

  assign alpha_hi = alpha_f > MAX_P;
  assign alpha_lo = alpha_f < MIN_P;
  assign beta_hi  = beta_f  > MAX_P;
  assign beta_lo  = beta_f  < MIN_P;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      en_d        <= 1'b0;
      mode_q      <= 1'b0;
      iu_q        <= '0;
      iv_q        <= '0;
      iw_q        <= '0;
      a_q         <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      alpha_f     <= '0;
      beta_f      <= '0;
      bus.oIalpha <= '0;
      bus.oIbeta  <= '0;
      bus.oSat    <= 1'b0;
      bus.oBusy   <= 1'b0;
      bus.oC_done <= 1'b0;
    end else begin
      // en_d tracks iC_en in every state so a level held through a
      // conversion cannot look like a fresh edge on return to IDLE.
      en_d        <= bus.iC_en;
      bus.oC_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= bus.iMode;
            iu_q      <= bus.iIu;
            iv_q      <= bus.iIv;
            iw_q      <= bus.iIw;
            bus.oBusy <= 1'b1;
            state     <= CAP;
          end
        end
        CAP: begin
          a_q   <= a_n;
          b1_q  <= b1_n;
          b2_q  <= b2_n;
          state <= MUL;
        end
        MUL: begin
          alpha_f <= alpha_n;
          beta_f  <= beta_n;
          state   <= OUT;
        end
        OUT: begin
          if (alpha_hi)      bus.oIalpha <= MAX_P[DATA_W-1:0];
          else if (alpha_lo) bus.oIalpha <= MIN_P[DATA_W-1:0];
          else               bus.oIalpha <= alpha_f[DATA_W-1:0];
          if (beta_hi)       bus.oIbeta  <= MAX_P[DATA_W-1:0];
          else if (beta_lo)  bus.oIbeta  <= MIN_P[DATA_W-1:0];
          else               bus.oIbeta  <= beta_f[DATA_W-1:0];
          bus.oSat    <= alpha_hi | alpha_lo | beta_hi | beta_lo;
          bus.oC_done <= 1'b1;
          bus.oBusy   <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          bus.oBusy <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clark_multi.sv
// tb_clark_multi: directed-vector bench for clark_multi. Expected results are
// hand-computed constants; all comparisons go through check().
module tb_clark_multi;
  localparam int DATA_W = 12;
  localparam int COEF_W = 10;

  logic iClk = 1'b0;
  logic iRst = 1'b1;

  clark_multi_if #(.DATA_W(DATA_W)) bus ();

  clark_multi #(.DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] busy_v;
  int          done_cnt;
  int          done_first;
  int          done_last;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Edge c (1..ncyc) sees iC_en = pat[c-1]; outputs sampled 1 ns after it.
  task automatic run_pattern(input logic [15:0] pat, input int ncyc, input bit corrupt);
    busy_v     = '0;
    done_cnt   = 0;
    done_first = -1;
    done_last  = -1;
    for (int c = 1; c <= ncyc; c++) begin
      bus.iC_en = pat[c-1];
      @(posedge iClk);
      #1;
      busy_v[c-1] = bus.oBusy;
      if (bus.oC_done) begin
        done_cnt++;
        if (done_first < 0) done_first = c;
        done_last = c;
      end
      if (corrupt && c == 1) begin
        bus.iIu   = 12'sd123;
        bus.iIv   = -12'sd777;
        bus.iIw   = 12'sd2000;
        bus.iMode = ~bus.iMode;
      end
    end
    bus.iC_en = 1'b0;
  endtask

  task automatic convert(input string tag, input bit mode, input int iu, input int iv,
                         input int iw, input int exp_a, input int exp_b,
                         input int exp_sat, input bit corrupt);
    bus.iMode = mode;
    bus.iIu   = DATA_W'(iu);
    bus.iIv   = DATA_W'(iv);
    bus.iIw   = DATA_W'(iw);
    run_pattern(16'h0001, 6, corrupt);
    check({tag, "_done_cnt"},   done_cnt, 1);
    check({tag, "_done_edge"},  done_first, 4);
    check({tag, "_busy_e0"},    int'(busy_v[0]), 1);
    check({tag, "_busy_e3"},    int'(busy_v[3]), 0);
    check({tag, "_alpha"},      int'(bus.oIalpha), exp_a);
    check({tag, "_beta"},       int'(bus.oIbeta), exp_b);
    check({tag, "_sat"},        int'(bus.oSat), exp_sat);
  endtask

  initial begin
    bus.iC_en = 1'b0;
    bus.iMode = 1'b0;
    bus.iIu   = '0;
    bus.iIv   = '0;
    bus.iIw   = '0;
    iRst      = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_alpha", int'(bus.oIalpha), 0);
    check("rst_beta",  int'(bus.oIbeta), 0);
    check("rst_sat",   int'(bus.oSat), 0);
    check("rst_busy",  int'(bus.oBusy), 0);
    check("rst_done",  int'(bus.oC_done), 0);
    iRst = 1'b0;
    @(posedge iClk);
    #1;

    convert("m0_pos",  1'b0,  1000,     0, 0,  1000,   577, 0, 1'b0);
    convert("m0_neg",  1'b0, -1000,     0, 0, -1000,  -578, 0, 1'b0);
    convert("m0_both", 1'b0,  1000,  1000, 0,  1000,  1731, 0, 1'b0);
    convert("m0_satp", 1'b0,  2047,  2047, 0,  2047,  2047, 1, 1'b0);
    convert("m0_satn", 1'b0, -2048, -2048, 0, -2048, -2048, 1, 1'b0);
    convert("m1_a",    1'b1,  1000,  -500, -500, 999,    0, 0, 1'b1);
    convert("m1_b",    1'b1,     0,  1000, -1000,  0, 1154, 0, 1'b1);

    // Held high for 10 edges: one conversion only.
    bus.iMode = 1'b0;
    bus.iIu   = 12'sd1000;
    bus.iIv   = 12'sd0;
    run_pattern(16'h03FF, 14, 1'b0);
    check("hold_done_cnt",  done_cnt, 1);
    check("hold_done_edge", done_first, 4);

    // Second rising edge at E2 is ignored; still high when IDLE returns.
    run_pattern(16'h003D, 12, 1'b0);
    check("e2_done_cnt",  done_cnt, 1);
    check("e2_done_edge", done_first, 4);

    // Rising edge at E4 is accepted; second done at E7.
    run_pattern(16'h0011, 12, 1'b0);
    check("e4_done_cnt",   done_cnt, 2);
    check("e4_done_first", done_first, 4);
    check("e4_done_last",  done_last, 8);

    // Reset at E1 aborts the conversion.
    bus.iMode = 1'b1;
    bus.iIu   = 12'sd1000;
    bus.iIv   = -12'sd500;
    bus.iIw   = -12'sd500;
    bus.iC_en = 1'b1;
    @(posedge iClk);
    #1;
    check("abort_busy_e0", int'(bus.oBusy), 1);
    iRst      = 1'b1;
    bus.iC_en = 1'b0;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    run_pattern(16'h0000, 6, 1'b0);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_alpha",    int'(bus.oIalpha), 0);
    check("abort_beta",     int'(bus.oIbeta), 0);
    check("abort_sat",      int'(bus.oSat), 0);
    check("abort_busy",     int'(bus.oBusy), 0);

    convert("post_rst", 1'b1, 1000, -500, -500, 999, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
